spi_cmd_decoder: RTL and testbench
==================================

// Module: spi_cmd_decoder
// PURPOSE
//  Command/transaction decoder directly downstream of the SPI byte deserializer, running in the sclk domain.
//  Consumes received bytes, decodes command byte [7]=WR, [6]=INC, [5:0]=addr, then handles 1..N data bytes.
//  Issues register write strobes and supplies the next byte to shift out (tx_byte) for reads.
//  The register file and the CDC into the PWM core clock domain are outside this block.
// PARAMETERS
//  REG_COUNT  64  number of implemented registers; addresses >= REG_COUNT are invalid (1..64)
// PORTS
//  sclk         in   1  SPI clock; all state changes on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  byte_valid   in   1  one-sclk-cycle pulse: byte_data holds a complete received byte
//  byte_data    in   8  received byte, MSB first as shifted
//  frame_first  in   1  qualifies byte_valid: first byte after cs_n fell
//  wr_en        out  1  one-cycle register write strobe
//  wr_addr      out  6  write address, valid with wr_en
//  wr_data      out  8  write data, valid with wr_en
//  rd_addr      out  6  combinational read address toward the register file
//  rd_data      in   8  combinational read data for rd_addr
//  tx_byte      out  8  byte to be shifted out during the next SPI byte
//  busy         out  1  state != IDLE
//  err          out  1  one-cycle pulse on a protocol/address error
//  err_cnt      out  8  saturating error count (holds at 255)
// BEHAVIOUR
//  Reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, tx_byte=0x00, err=0, err_cnt=0, addr_q=0.
//  FSM states: IDLE, WR_DATA, RD_DATA, HOLD.
//  byte_valid & frame_first in any state: decode as a command. Any partial transaction is abandoned; no write is issued for it.
//   WR=1 -> WR_DATA. WR=0 -> RD_DATA. addr_q<=byte[5:0], inc_q<=byte[6].
//  WR_DATA, byte_valid & !frame_first:
//   If addr_q < REG_COUNT: wr_en=1 next cycle, with wr_addr=addr_q and wr_data=byte.
//   Else: no wr_en; err pulse.
//   Then: if inc_q, addr_q<=addr_q+1 (mod 64) and stay in WR_DATA; else go to HOLD.
//  RD_DATA, byte_valid & !frame_first (dummy byte): the byte is ignored.
//   If inc_q, addr_q+1 (mod 64) and stay in RD_DATA; else go to HOLD.
//  rd_addr (combinational):
//   byte_data[5:0] when byte_valid & frame_first;
//   addr_q+1 when byte_valid in RD_DATA & inc_q;
//   addr_q otherwise.
//  tx_byte: at each edge where a read command or burst dummy byte is accepted, tx_byte <= rd_data.
//   If rd_addr >= REG_COUNT, tx_byte <= 0x00 and err pulses.
//   Latency: 1 sclk after byte_valid. All other byte_valid events load tx_byte<=0x00.
//  byte_valid & !frame_first in IDLE or HOLD: byte ignored, err pulse.
//  err_cnt increments on every err pulse and saturates at 8'hFF.
//  wr_en and err are single-cycle; they never assert without byte_valid on the preceding edge.
//  Address wrap: 0x3F+1 -> 0x00 in both burst modes.
//  rst_n assertion mid-transaction: immediate return to reset values. A pending wr_en is dropped.
// STRUCTURE
//  Shared package spi_cmd_pkg:
//   CMD_WR_BIT=7, CMD_INC_BIT=6, ADDR_W=6
//   state typedef/localparams IDLE/WR_DATA/RD_DATA/HOLD
//  One natural sub-module: sat_counter (8-bit, inc pulse, saturating), used for err_cnt.
//  The rest is a single FSM plus registers; no memories.
// TESTING
//  1 Single write: bytes 0x85(first), 0xA5 -> one wr_en, wr_addr=0x05, wr_data=0xA5; state HOLD; err_cnt=0.
//  2 Burst write + wrap: 0xFE(first), 0x11, 0x22, 0x33 -> wr_en at addresses 0x3E, 0x3F, 0x00 with data 0x11, 0x22, 0x33.
//  3 Read: model mem[k]=k^0x5A; 0x07(first) -> tx_byte=0x5D one cycle later.
//    Burst 0x47, 0x00, 0x00 -> tx_byte 0x5D, then 0x52, then 0x53.
//  4 Invalid address with REG_COUNT=16: 0xA0(first), 0xFF -> no wr_en, err pulse, err_cnt=1.
//    Read 0x20 -> tx_byte=0x00, err_cnt=2.
//  5 Protocol errors: 0x81(first), 0x10, 0x20 -> one write (addr 1, data 0x10); third byte errs.
//    300 stray bytes in IDLE -> err_cnt saturates at 255.
//  6 Abort/reset: 0xC2(first), 0x01, then 0x85(first), 0x99 -> writes (2,0x01), (5,0x99) only.
//    rst_n low between a data byte_valid and the next edge -> no wr_en, all outputs at reset values.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command decoder.
package spi_cmd_pkg;

    // Command byte layout: [7]=WR, [6]=INC, [5:0]=register address
    localparam int unsigned CMD_WR_BIT  = 7;
    localparam int unsigned CMD_INC_BIT = 6;
    localparam int unsigned ADDR_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_DATA,
        HOLD
    } state_e;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Bus between the SPI byte deserializer / register file and the command decoder.
interface spi_cmd_decoder_if;
    import spi_cmd_pkg::*;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_first;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        tx_byte;
    logic              busy;
    logic              err;
    logic [7:0]        err_cnt;

    // Deserializer + register file side
    modport master (
        output byte_valid, byte_data, frame_first, rd_data,
        input  wr_en, wr_addr, wr_data, rd_addr, tx_byte, busy, err, err_cnt
    );

    // Decoder side
    modport slave (
        input  byte_valid, byte_data, frame_first, rd_data,
        output wr_en, wr_addr, wr_data, rd_addr, tx_byte, busy, err, err_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: advances once per i_inc pulse, holds at all-ones.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [Width-1:0] o_count
);

    logic [Width-1:0] r_count;

    // Count up on each pulse until the all-ones ceiling
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {Width{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command/transaction decoder: turns received bytes into register writes and read data.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned REG_COUNT = 64
) (
    input  logic             sclk,
    input  logic             rst_n,
    spi_cmd_decoder_if.slave bus
);

    // One extra bit so REG_COUNT=64 compares as "every address valid"
    localparam logic [ADDR_W:0] RegLimit = REG_COUNT[ADDR_W:0];

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inc;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_tx_byte;
    logic              r_err;

    logic              w_cmd;
    logic              w_data;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [7:0]        w_err_cnt;

    assign w_cmd       = bus.byte_valid & bus.frame_first;
    assign w_data      = bus.byte_valid & ~bus.frame_first;
    assign w_addr_next = r_addr + 1'b1;  // wraps 0x3F -> 0x00
    assign w_rd_ok     = {1'b0, w_rd_addr} < RegLimit;
    assign w_wr_ok     = {1'b0, r_addr} < RegLimit;

    // Read address looks ahead so rd_data is ready at the edge that loads tx_byte
    always_comb begin
        w_rd_addr = r_addr;
        if (w_cmd) begin
            w_rd_addr = bus.byte_data[ADDR_W-1:0];
        end else if (bus.byte_valid && (r_state == RD_DATA) && r_inc) begin
            w_rd_addr = w_addr_next;
        end
    end

    // Transaction FSM with registered strobes and shift-out byte
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_inc     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_tx_byte <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            if (bus.byte_valid) begin
                // Default for every byte event; read paths override below
                r_tx_byte <= 8'h00;
            end
            if (w_cmd) begin
                // A new command abandons whatever was in flight
                r_addr <= bus.byte_data[ADDR_W-1:0];
                r_inc  <= bus.byte_data[CMD_INC_BIT];
                if (bus.byte_data[CMD_WR_BIT]) begin
                    r_state <= WR_DATA;
                end else begin
                    r_state <= RD_DATA;
                    if (w_rd_ok) begin
                        r_tx_byte <= bus.rd_data;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (w_data) begin
                unique case (r_state)
                    WR_DATA: begin
                        if (w_wr_ok) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= bus.byte_data;
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (r_inc) begin
                            r_addr <= w_addr_next;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                    RD_DATA: begin
                        // Dummy byte; only a burst fetches the next register
                        if (r_inc) begin
                            r_addr <= w_addr_next;
                            if (w_rd_ok) begin
                                r_tx_byte <= bus.rd_data;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                    IDLE, HOLD: begin
                        r_err <= 1'b1;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .Width(8)
    ) u_err_cnt (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .i_inc  (r_err),
        .o_count(w_err_cnt)
    );

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.rd_addr = w_rd_addr;
    assign bus.tx_byte = r_tx_byte;
    assign bus.busy    = (r_state != IDLE);
    assign bus.err     = r_err;
    assign bus.err_cnt = w_err_cnt;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: table of byte vectors plus corner-case sequences.
module tb_spi_cmd_decoder;

    logic       sclk;
    logic       rst_n;
    logic       byte_valid;
    logic       frame_first;
    logic [7:0] byte_data;

    int n_checks;
    int n_fail;

    spi_cmd_decoder_if bus_a ();
    spi_cmd_decoder_if bus_b ();

    // Both instances see the same byte stream; register file model is mem[k] = k ^ 0x5A
    assign bus_a.byte_valid  = byte_valid;
    assign bus_a.frame_first = frame_first;
    assign bus_a.byte_data   = byte_data;
    assign bus_a.rd_data     = {2'b00, bus_a.rd_addr} ^ 8'h5A;
    assign bus_b.byte_valid  = byte_valid;
    assign bus_b.frame_first = frame_first;
    assign bus_b.byte_data   = byte_data;
    assign bus_b.rd_data     = {2'b00, bus_b.rd_addr} ^ 8'h5A;

    spi_cmd_decoder #(
        .REG_COUNT(64)
    ) u_dut_a (
        .sclk (sclk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    spi_cmd_decoder #(
        .REG_COUNT(16)
    ) u_dut_b (
        .sclk (sclk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    typedef struct packed {
        logic       first;
        logic [7:0] data;
        logic       wr_en;
        logic [5:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] tx;
        logic       err;
        logic [7:0] cnt;
        logic       busy;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge: holds the byte across one posedge, returns at the next negedge
    task automatic send(input logic first, input logic [7:0] data);
        byte_valid  = 1'b1;
        frame_first = first;
        byte_data   = data;
        @(negedge sclk);
        byte_valid  = 1'b0;
        frame_first = 1'b0;
    endtask

    task automatic idle();
        @(negedge sclk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        byte_valid  = 1'b0;
        frame_first = 1'b0;
        byte_data   = 8'h00;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //        first data   wr  waddr  wdata  tx     err cnt    busy
        vecs[0]  = '{1'b1, 8'h85, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[1]  = '{1'b0, 8'hA5, 1'b1, 6'h05, 8'hA5, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[2]  = '{1'b1, 8'hFE, 1'b0, 6'h05, 8'hA5, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[3]  = '{1'b0, 8'h11, 1'b1, 6'h3E, 8'h11, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[4]  = '{1'b0, 8'h22, 1'b1, 6'h3F, 8'h22, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[5]  = '{1'b0, 8'h33, 1'b1, 6'h00, 8'h33, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[6]  = '{1'b1, 8'h07, 1'b0, 6'h00, 8'h33, 8'h5D, 1'b0, 8'd0, 1'b1};
        vecs[7]  = '{1'b1, 8'h47, 1'b0, 6'h00, 8'h33, 8'h5D, 1'b0, 8'd0, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 6'h00, 8'h33, 8'h52, 1'b0, 8'd0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 6'h00, 8'h33, 8'h53, 1'b0, 8'd0, 1'b1};
        vecs[10] = '{1'b1, 8'h7F, 1'b0, 6'h00, 8'h33, 8'h65, 1'b0, 8'd0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 6'h00, 8'h33, 8'h5A, 1'b0, 8'd0, 1'b1};
        vecs[12] = '{1'b1, 8'h81, 1'b0, 6'h00, 8'h33, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[13] = '{1'b0, 8'h10, 1'b1, 6'h01, 8'h10, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[14] = '{1'b0, 8'h20, 1'b0, 6'h01, 8'h10, 8'h00, 1'b1, 8'd0, 1'b1};
        vecs[15] = '{1'b1, 8'hC2, 1'b0, 6'h01, 8'h10, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[16] = '{1'b0, 8'h01, 1'b1, 6'h02, 8'h01, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[17] = '{1'b1, 8'h85, 1'b0, 6'h02, 8'h01, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[18] = '{1'b0, 8'h99, 1'b1, 6'h05, 8'h99, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[19] = '{1'b1, 8'h07, 1'b0, 6'h05, 8'h99, 8'h5D, 1'b0, 8'd1, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 6'h05, 8'h99, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 6'h05, 8'h99, 8'h00, 1'b1, 8'd1, 1'b1};

        rst_n = 1'b0;
        @(negedge sclk);
        do_reset();

        // Reset state
        check("reset wr_en",   32'(bus_a.wr_en),   32'd0);
        check("reset wr_addr", 32'(bus_a.wr_addr), 32'd0);
        check("reset wr_data", 32'(bus_a.wr_data), 32'd0);
        check("reset tx_byte", 32'(bus_a.tx_byte), 32'd0);
        check("reset err",     32'(bus_a.err),     32'd0);
        check("reset err_cnt", 32'(bus_a.err_cnt), 32'd0);
        check("reset busy",    32'(bus_a.busy),    32'd0);

        // Writes, bursts with wrap, reads, protocol error, abort
        for (int i = 0; i < 22; i++) begin
            send(vecs[i].first, vecs[i].data);
            check($sformatf("vec%0d wr_en", i),   32'(bus_a.wr_en),   32'(vecs[i].wr_en));
            check($sformatf("vec%0d wr_addr", i), 32'(bus_a.wr_addr), 32'(vecs[i].wr_addr));
            check($sformatf("vec%0d wr_data", i), 32'(bus_a.wr_data), 32'(vecs[i].wr_data));
            check($sformatf("vec%0d tx_byte", i), 32'(bus_a.tx_byte), 32'(vecs[i].tx));
            check($sformatf("vec%0d err", i),     32'(bus_a.err),     32'(vecs[i].err));
            check($sformatf("vec%0d err_cnt", i), 32'(bus_a.err_cnt), 32'(vecs[i].cnt));
            check($sformatf("vec%0d busy", i),    32'(bus_a.busy),    32'(vecs[i].busy));
        end
        idle();
        check("post wr_en",   32'(bus_a.wr_en),   32'd0);
        check("post err",     32'(bus_a.err),     32'd0);
        check("post err_cnt", 32'(bus_a.err_cnt), 32'd2);
        check("post busy",    32'(bus_a.busy),    32'd1);

        // Invalid addresses with REG_COUNT=16
        do_reset();
        send(1'b1, 8'hA0);
        check("inv cmd err", 32'(bus_b.err), 32'd0);
        send(1'b0, 8'hFF);
        check("inv wr_en",   32'(bus_b.wr_en), 32'd0);
        check("inv wr err",  32'(bus_b.err),   32'd1);
        idle();
        check("inv cnt1",    32'(bus_b.err_cnt), 32'd1);
        check("inv err off", 32'(bus_b.err),     32'd0);
        send(1'b1, 8'h20);
        check("inv rd tx",   32'(bus_b.tx_byte), 32'h00);
        check("inv rd err",  32'(bus_b.err),     32'd1);
        idle();
        check("inv cnt2",    32'(bus_b.err_cnt), 32'd2);
        send(1'b1, 8'h0F);
        check("b rd 0f tx",  32'(bus_b.tx_byte), 32'h55);
        check("b rd 0f err", 32'(bus_b.err),     32'd0);
        send(1'b1, 8'h4F);
        check("b burst tx0", 32'(bus_b.tx_byte), 32'h55);
        send(1'b0, 8'h00);
        check("b burst tx1", 32'(bus_b.tx_byte), 32'h00);
        check("b burst err", 32'(bus_b.err),     32'd1);
        idle();
        check("b cnt3",      32'(bus_b.err_cnt), 32'd3);

        // Stray bytes in IDLE saturate the error counter
        do_reset();
        for (int i = 0; i < 254; i++) send(1'b0, 8'h5A);
        idle();
        check("sat cnt254", 32'(bus_a.err_cnt), 32'd254);
        check("sat busy",   32'(bus_a.busy),    32'd0);
        for (int i = 0; i < 46; i++) send(1'b0, 8'hA5);
        check("sat err pulse", 32'(bus_a.err), 32'd1);
        idle();
        check("sat cnt255", 32'(bus_a.err_cnt), 32'd255);

        // Reset between a data byte and the edge that would write it
        do_reset();
        send(1'b0, 8'h33);
        send(1'b1, 8'h85);
        check("rst pre cnt", 32'(bus_a.err_cnt), 32'd1);
        byte_valid  = 1'b1;
        frame_first = 1'b0;
        byte_data   = 8'h99;
        #2 rst_n = 1'b0;
        @(negedge sclk);
        check("rst wr_en",   32'(bus_a.wr_en),   32'd0);
        check("rst wr_addr", 32'(bus_a.wr_addr), 32'd0);
        check("rst wr_data", 32'(bus_a.wr_data), 32'd0);
        check("rst tx_byte", 32'(bus_a.tx_byte), 32'd0);
        check("rst err",     32'(bus_a.err),     32'd0);
        check("rst err_cnt", 32'(bus_a.err_cnt), 32'd0);
        check("rst busy",    32'(bus_a.busy),    32'd0);
        check("rst rd_addr", 32'(bus_a.rd_addr), 32'd0);
        byte_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge sclk);
        check("rst after wr_en", 32'(bus_a.wr_en), 32'd0);
        check("rst after busy",  32'(bus_a.busy),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
